wb_hid_report_fetcher: RTL and testbench
========================================

WB_HID_REPORT_FETCHER -- requirements
Module: wb_hid_report_fetcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning report FIFO entries; power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 255, meaning max wb_clk cycles from request acceptance to ack/err before abort.
REQ-003 wb_clk  input  1  system clock; single clock domain.
REQ-004 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  when high, fetcher services irq.
REQ-006 irq  input  1  level interrupt from HID host slave; high while report pending.
REQ-007 wbm_adr  output  4  word address to HID host slave.
REQ-008 wbm_dat_w  output  32  write data.
REQ-009 wbm_dat_r  input  32  read data.
REQ-010 wbm_sel  output  4  byte selects, constant 4'hF.
REQ-011 wbm_cyc, wbm_stb, wbm_we  output  1 each  pipelined Wishbone master controls.
REQ-012 wbm_stall, wbm_ack, wbm_err  input  1 each  pipelined Wishbone slave responses.
REQ-013 out_valid  output  1  FIFO head valid.
REQ-014 out_ready  input  1  consumer pops head when out_valid && out_ready.
REQ-015 out_typ  output  2  head record device type (1 kbd, 2 mouse, 3 gamepad).
REQ-016 out_conerr  output  1  head record connection-error flag.
REQ-017 out_data  output  64  head record payload.
REQ-018 bus_err  output  1  sticky; set on wbm_err or timeout.

Function
REQ-019 States: INIT, IDLE, RD_STAT, RD_P0, RD_P1, WAIT_SPACE, CLR_ISR; one Wishbone transaction outstanding at most.
REQ-020 Transaction: cyc=stb=1 with adr/we/dat_w stable; stb drops the cycle after an edge sampling stall=0; cyc drops the cycle after ack or err; next transaction no earlier than the cycle after cyc drops.
REQ-021 Timeout counter starts at acceptance, counts wb_clk cycles; when it reaches TIMEOUT without ack/err, drop cyc, set bus_err, abort.
REQ-022 INIT: write adr 0 data 1 (enable slave irq); on ack -> IDLE; on abort retry INIT.
REQ-023 IDLE: enable && irq -> RD_STAT; otherwise stay.
REQ-024 RD_STAT: read adr 2; capture typ=dat_r[1:0], conerr=dat_r[2]; typ 0 -> CLR_ISR without push; else -> RD_P0.
REQ-025 RD_P0: typ1 read adr 3 -> RD_P1; typ2 read adr 5 -> WAIT_SPACE; typ3 read adr 6 -> WAIT_SPACE.
REQ-026 RD_P1 (typ1 only): read adr 4 -> WAIT_SPACE.
REQ-027 Payload: kbd {24'b0, adr3[7:0], adr4[31:0]}; mouse {40'b0, adr5[23:0]}; gamepad {54'b0, adr6[9:0]}; bits not listed are zero.
REQ-028 WAIT_SPACE: push {typ, conerr, payload} when FIFO not full, then -> CLR_ISR; while full, hold, no bus activity, no record dropped.
REQ-029 CLR_ISR: write adr 1 data 0; on ack -> IDLE.
REQ-030 Any abort in RD_STAT/RD_P0/RD_P1/CLR_ISR -> IDLE with partial record discarded.
REQ-031 FIFO: push and pop in the same cycle when full or empty both succeed if legal (pop-from-empty ignored; push to full never issued); pointers wrap modulo FIFO_DEPTH.
REQ-032 out_valid high exactly when FIFO count > 0; out_typ/out_conerr/out_data reflect head combinationally from storage; no bubble on back-to-back pops.
REQ-033 enable low mid-sequence does not abort; sequence completes, then IDLE waits.
REQ-034 Latency irq high (IDLE) to cyc high: 1 cycle.

Reset
REQ-035 On sys_rst_n low at clock edge: state INIT, cyc=stb=we=0, adr=0, dat_w=0, FIFO empty, out_valid=0, bus_err=0, timeout counter 0; sel=4'hF.
REQ-036 Reset mid-transaction drops cyc next cycle; late ack after reset ignored.

Verification
REQ-037 After reset, slave acks 1 cycle: write adr0=1 seen, then idle with cyc=0 -> state IDLE.
REQ-038 irq, adr2=1, adr3=0x02, adr4=0x00001D04 -> reads 2,3,4, write 1; out_data=0x0000_0002_0000_1D04, out_typ=1.
REQ-039 Mouse adr2=2, adr5=0x0001FF05, stall high 3 cycles on each request -> stb held 3 extra cycles; out_data=0x1FF05.
REQ-040 FIFO_DEPTH=4, out_ready=0, 5 irq reports -> 4 queued, 5th holds in WAIT_SPACE, no adr1 write; one pop -> 5th pushed, then CLR_ISR.
REQ-041 Slave never acks adr2 read -> cyc drops TIMEOUT cycles after acceptance, bus_err=1, state IDLE, FIFO unchanged.
REQ-042 wbm_err on adr5 read -> bus_err=1, no push, next irq serviced normally; reset clears bus_err to 0.

Source files
------------

// File: rtl/wb_hid_report_fetcher.sv
// HID report fetcher: a pipelined Wishbone master that drains pending reports
// from an HID host slave into a small record FIFO.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// INIT       | write adr0=1 to enable slave irq, retried until acked
// IDLE       | wait for enable && irq
// RD_STAT    | read adr2: device type and connection-error flag
// RD_P0      | read first payload word (adr3 kbd, adr5 mouse, adr6 gamepad)
// RD_P1      | read second keyboard payload word (adr4)
// WAIT_SPACE | hold the assembled record until the FIFO has room, then push
// CLR_ISR    | write adr1=0 to clear the slave interrupt
module wb_hid_report_fetcher #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        wb_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    input  logic        irq,
    output logic [3:0]  wbm_adr,
    output logic [31:0] wbm_dat_w,
    input  logic [31:0] wbm_dat_r,
    output logic [3:0]  wbm_sel,
    output logic        wbm_cyc,
    output logic        wbm_stb,
    output logic        wbm_we,
    input  logic        wbm_stall,
    input  logic        wbm_ack,
    input  logic        wbm_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_typ,
    output logic        out_conerr,
    output logic [63:0] out_data,
    output logic        bus_err
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMR_LAST = TW'(1);

    typedef enum logic [2:0] {
        INIT, IDLE, RD_STAT, RD_P0, RD_P1, WAIT_SPACE, CLR_ISR
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q;
    logic [1:0]    typ_q;
    logic          conerr_q;
    logic [63:0]   payload_q;

    logic [66:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic          accept, got_ack, got_err, tmo, abort;
    logic          launch, push, pop, full;
    logic [3:0]    l_adr;
    logic          l_we;
    logic [31:0]   l_dat;

    assign wbm_sel = 4'hF;

    // Bus response decode; err wins over ack, timeout only while waiting after acceptance.
    assign accept  = wbm_stb && !wbm_stall;
    assign got_err = wbm_cyc && wbm_err;
    assign got_ack = wbm_cyc && wbm_ack && !wbm_err;
    assign tmo     = wbm_cyc && !wbm_stb && !wbm_ack && !wbm_err && (tmr_q == TMR_LAST);
    assign abort   = got_err || tmo;

    // State register.
    always_ff @(posedge wb_clk) begin
        if (!sys_rst_n) state_q <= INIT;
        else            state_q <= state_d;
    end

    // Next state; bus states launch their transaction once cyc is low, IDLE launches on the way out.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        push    = 1'b0;
        case (state_q)
            INIT: begin
                if (!wbm_cyc)     launch  = 1'b1;
                else if (got_ack) state_d = IDLE;
            end
            IDLE: begin
                if (enable && irq) begin
                    launch  = 1'b1;
                    state_d = RD_STAT;
                end
            end
            RD_STAT: begin
                if (!wbm_cyc)     launch  = 1'b1;
                else if (got_ack) state_d = (wbm_dat_r[1:0] == 2'd0) ? CLR_ISR : RD_P0;
                else if (abort)   state_d = IDLE;
            end
            RD_P0: begin
                if (!wbm_cyc)     launch  = 1'b1;
                else if (got_ack) state_d = (typ_q == 2'd1) ? RD_P1 : WAIT_SPACE;
                else if (abort)   state_d = IDLE;
            end
            RD_P1: begin
                if (!wbm_cyc)     launch  = 1'b1;
                else if (got_ack) state_d = WAIT_SPACE;
                else if (abort)   state_d = IDLE;
            end
            WAIT_SPACE: begin
                if (!full) begin
                    push    = 1'b1;
                    state_d = CLR_ISR;
                end
            end
            CLR_ISR: begin
                if (!wbm_cyc)               launch  = 1'b1;
                else if (got_ack || abort)  state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // Address/data of the transaction the current state launches.
    always_comb begin
        l_adr = 4'd2;
        l_we  = 1'b0;
        l_dat = 32'd0;
        case (state_q)
            INIT: begin
                l_adr = 4'd0;
                l_we  = 1'b1;
                l_dat = 32'd1;
            end
            RD_P0: begin
                case (typ_q)
                    2'd1:    l_adr = 4'd3;
                    2'd2:    l_adr = 4'd5;
                    default: l_adr = 4'd6;
                endcase
            end
            RD_P1: l_adr = 4'd4;
            CLR_ISR: begin
                l_adr = 4'd1;
                l_we  = 1'b1;
            end
            default: l_adr = 4'd2;
        endcase
    end

    // Wishbone master controls, timeout down-counter and sticky error flag.
    always_ff @(posedge wb_clk) begin
        if (!sys_rst_n) begin
            wbm_cyc   <= 1'b0;
            wbm_stb   <= 1'b0;
            wbm_we    <= 1'b0;
            wbm_adr   <= 4'd0;
            wbm_dat_w <= 32'd0;
            tmr_q     <= '0;
            bus_err   <= 1'b0;
        end else begin
            if (launch) begin
                wbm_cyc   <= 1'b1;
                wbm_stb   <= 1'b1;
                wbm_adr   <= l_adr;
                wbm_we    <= l_we;
                wbm_dat_w <= l_dat;
            end else if (wbm_cyc) begin
                if (got_ack || abort) begin
                    wbm_cyc <= 1'b0;
                    wbm_stb <= 1'b0;
                    tmr_q   <= '0;
                end else if (accept) begin
                    wbm_stb <= 1'b0;
                    tmr_q   <= TMR_LOAD;
                end else if (!wbm_stb && tmr_q != '0) begin
                    tmr_q   <= tmr_q - TMR_LAST;
                end
            end
            if (abort) bus_err <= 1'b1;
        end
    end

    // Record assembly from acked reads; unused payload bits stay zero.
    always_ff @(posedge wb_clk) begin
        if (!sys_rst_n) begin
            typ_q     <= 2'd0;
            conerr_q  <= 1'b0;
            payload_q <= 64'd0;
        end else if (got_ack) begin
            case (state_q)
                RD_STAT: begin
                    typ_q    <= wbm_dat_r[1:0];
                    conerr_q <= wbm_dat_r[2];
                end
                RD_P0: begin
                    case (typ_q)
                        2'd1:    payload_q <= {24'd0, wbm_dat_r[7:0], 32'd0};
                        2'd2:    payload_q <= {40'd0, wbm_dat_r[23:0]};
                        default: payload_q <= {54'd0, wbm_dat_r[9:0]};
                    endcase
                end
                RD_P1:   payload_q[31:0] <= wbm_dat_r;
                default: ;
            endcase
        end
    end

    assign full      = (count == DEPTH_C);
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign {out_typ, out_conerr, out_data} = fifo_mem[rd_ptr];

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge wb_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // FIFO storage write.
    always_ff @(posedge wb_clk) begin
        if (push) fifo_mem[wr_ptr] <= {typ_q, conerr_q, payload_q};
    end

endmodule

// File: tb/tb_wb_hid_report_fetcher.sv
// Directed bench for wb_hid_report_fetcher with a reactive HID slave model.
module tb_wb_hid_report_fetcher;
    localparam int TMO = 255;

    typedef struct packed {
        logic [3:0]  adr;
        logic        we;
        logic [31:0] dat;
    } txn_t;

    logic        wb_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        irq;
    logic [3:0]  wbm_adr;
    logic [31:0] wbm_dat_w;
    logic [31:0] wbm_dat_r;
    logic [3:0]  wbm_sel;
    logic        wbm_cyc, wbm_stb, wbm_we;
    logic        wbm_stall, wbm_ack, wbm_err;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_typ;
    logic        out_conerr;
    logic [63:0] out_data;
    logic        bus_err;

    int n_chk = 0;
    int n_bad = 0;

    // stimulus-owned slave configuration
    logic [31:0] regs [0:7];
    int pend_set  = 0;
    int stall_cfg = 0;
    int err_adr   = -1;
    int noack_adr = -1;

    // slave-owned state
    txn_t log_q [$];
    int clr_cnt = 0, gp_reads = 0;
    int stb_len = 0, stb_len_sum = 0, stb_txn_cnt = 0;
    int accept_cyc = 0, drop_cyc = 0, cyc_cnt = 0;
    int stall_left = 0;
    bit resp_pend, seen, prev_cyc, resp_we;
    logic [3:0] resp_adr;

    assign irq = (pend_set > clr_cnt);

    wb_hid_report_fetcher #(.FIFO_DEPTH(4), .TIMEOUT(TMO)) dut (
        .wb_clk(wb_clk), .sys_rst_n(sys_rst_n), .enable(enable), .irq(irq),
        .wbm_adr(wbm_adr), .wbm_dat_w(wbm_dat_w), .wbm_dat_r(wbm_dat_r), .wbm_sel(wbm_sel),
        .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_we(wbm_we),
        .wbm_stall(wbm_stall), .wbm_ack(wbm_ack), .wbm_err(wbm_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_typ(out_typ),
        .out_conerr(out_conerr), .out_data(out_data), .bus_err(bus_err)
    );

    initial forever #5 wb_clk = ~wb_clk;

    always @(posedge wb_clk) cyc_cnt <= cyc_cnt + 1;

    // Slave model: decides stall/ack/err on the falling edge, logs every accepted request.
    always @(negedge wb_clk) begin
        if (!sys_rst_n) begin
            wbm_stall = 1'b0;
            wbm_ack   = 1'b0;
            wbm_err   = 1'b0;
            wbm_dat_r = 32'd0;
            resp_pend = 1'b0;
            seen      = 1'b0;
            prev_cyc  = 1'b0;
            stb_len   = 0;
        end else begin
            wbm_ack = 1'b0;
            wbm_err = 1'b0;
            if (prev_cyc && !wbm_cyc) drop_cyc = cyc_cnt;
            prev_cyc = wbm_cyc;
            if (wbm_stb) stb_len++;
            else if (stb_len != 0) begin
                stb_len_sum += stb_len;
                stb_txn_cnt++;
                stb_len = 0;
            end
            if (resp_pend) begin
                resp_pend = 1'b0;
                if (int'(resp_adr) == err_adr) wbm_err = 1'b1;
                else if (int'(resp_adr) != noack_adr) begin
                    wbm_ack = 1'b1;
                    if (!resp_we) begin
                        if (resp_adr == 4'd6) begin
                            wbm_dat_r = regs[6] + 32'(gp_reads);
                            gp_reads++;
                        end else wbm_dat_r = regs[resp_adr[2:0]];
                    end
                end
            end
            if (wbm_cyc && wbm_stb) begin
                if (!seen) begin
                    seen = 1'b1;
                    stall_left = stall_cfg;
                end
                if (stall_left > 0) begin
                    wbm_stall = 1'b1;
                    stall_left--;
                end else begin
                    wbm_stall  = 1'b0;
                    seen       = 1'b0;
                    resp_pend  = 1'b1;
                    resp_adr   = wbm_adr;
                    resp_we    = wbm_we;
                    accept_cyc = cyc_cnt + 1;
                    log_q.push_back('{adr: wbm_adr, we: wbm_we, dat: wbm_dat_w});
                    if (wbm_we && wbm_adr == 4'd1) clr_cnt++;
                end
            end else wbm_stall = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge wb_clk);
        #1;
    endtask

    task automatic wait_quiet(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 2 && n < 1000) begin
            tick();
            n++;
            if (!irq && !wbm_cyc) quiet++;
            else quiet = 0;
        end
        chk({tag, "_quiet"}, 64'(quiet), 64'd2);
    endtask

    task automatic wait_init(input string tag);
        int b = log_q.size();
        bit ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (log_q.size() > b && !wbm_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_init_done"}, 64'(ok), 64'd1);
        chk({tag, "_init_adr"}, 64'(log_q[b].adr), 64'd0);
        chk({tag, "_init_we"}, 64'(log_q[b].we), 64'd1);
        chk({tag, "_init_dat"}, 64'(log_q[b].dat), 64'd1);
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_seq(input string tag, input int b, input int n,
                           input logic [3:0] a0, input logic [3:0] a1,
                           input logic [3:0] a2, input logic [3:0] a3);
        logic [3:0] ea [4];
        ea = '{a0, a1, a2, a3};
        chk({tag, "_ntxn"}, 64'(log_q.size() - b), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_adr%0d", tag, i), 64'(log_q[b + i].adr), 64'(ea[i]));
            chk($sformatf("%s_we%0d", tag, i), 64'(log_q[b + i].we), 64'(ea[i] == 4'd1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int b, c0, s0, t0, n;
        bit ok;
        for (int i = 0; i < 8; i++) regs[i] = 32'd0;

        // reset values
        sys_rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_cyc", 64'(wbm_cyc), 64'd0);
        chk("rst_stb", 64'(wbm_stb), 64'd0);
        chk("rst_we", 64'(wbm_we), 64'd0);
        chk("rst_adr", 64'(wbm_adr), 64'd0);
        chk("rst_datw", 64'(wbm_dat_w), 64'd0);
        chk("rst_sel", 64'(wbm_sel), 64'hF);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_buserr", 64'(bus_err), 64'd0);
        sys_rst_n = 1'b1;
        wait_init("r1");
        repeat (5) tick();
        chk("idle_cyc", 64'(wbm_cyc), 64'd0);

        // keyboard report, one-cycle launch latency
        regs[2] = 32'd1; regs[3] = 32'h02; regs[4] = 32'h0000_1D04;
        b = log_q.size();
        pend_set = clr_cnt + 1;
        tick();
        chk("kbd_lat_cyc", 64'(wbm_cyc), 64'd1);
        chk("kbd_lat_adr", 64'(wbm_adr), 64'd2);
        wait_quiet("kbd");
        chk_seq("kbd", b, 4, 4'd2, 4'd3, 4'd4, 4'd1);
        chk("kbd_clr_dat", 64'(log_q[b + 3].dat), 64'd0);
        chk("kbd_valid", 64'(out_valid), 64'd1);
        chk("kbd_data", out_data, 64'h0000_0002_0000_1D04);
        chk("kbd_typ", 64'(out_typ), 64'd1);
        chk("kbd_conerr", 64'(out_conerr), 64'd0);
        pop_one();
        chk("kbd_popped", 64'(out_valid), 64'd0);

        // mouse with three stall cycles per request, conerr set
        stall_cfg = 3;
        regs[2] = 32'd6; regs[5] = 32'h0001_FF05;
        b = log_q.size(); s0 = stb_len_sum; t0 = stb_txn_cnt;
        pend_set = clr_cnt + 1;
        wait_quiet("mouse");
        chk_seq("mouse", b, 3, 4'd2, 4'd5, 4'd1, 4'd0);
        chk("mouse_stb_txns", 64'(stb_txn_cnt - t0), 64'd3);
        chk("mouse_stb_cycles", 64'(stb_len_sum - s0), 64'd12);
        chk("mouse_data", out_data, 64'h0000_0000_0001_FF05);
        chk("mouse_typ", 64'(out_typ), 64'd2);
        chk("mouse_conerr", 64'(out_conerr), 64'd1);
        pop_one();
        stall_cfg = 0;

        // five gamepad reports into a four-entry FIFO with no consumer
        regs[2] = 32'hFFFF_FFF3;
        regs[6] = 32'hFFFF_FC01 - 32'(gp_reads);
        b = log_q.size(); c0 = clr_cnt;
        pend_set = clr_cnt + 5;
        repeat (150) tick();
        chk("full_ntxn", 64'(log_q.size() - b), 64'd14);
        chk("full_clr", 64'(clr_cnt - c0), 64'd4);
        chk("full_last_adr", 64'(log_q[b + 13].adr), 64'd6);
        chk("full_cyc", 64'(wbm_cyc), 64'd0);
        chk("full_head", out_data, 64'd1);
        chk("full_typ", 64'(out_typ), 64'd3);
        chk("full_conerr", 64'(out_conerr), 64'd0);
        pop_one();
        wait_quiet("full");
        chk("full_clr5", 64'(clr_cnt - c0), 64'd5);
        chk("full_ntxn15", 64'(log_q.size() - b), 64'd15);
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("drain_valid%0d", k), 64'(out_valid), 64'd1);
            chk($sformatf("drain_data%0d", k), out_data, 64'(k));
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", 64'(out_valid), 64'd0);

        // slave never acks the status read
        noack_adr = 2;
        regs[2] = 32'd1;
        b = log_q.size();
        pend_set = clr_cnt + 1;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (log_q.size() > b && !wbm_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        pend_set = clr_cnt;
        chk("tmo_done", 64'(ok), 64'd1);
        chk("tmo_len", 64'(drop_cyc - accept_cyc), 64'(TMO));
        chk("tmo_buserr", 64'(bus_err), 64'd1);
        chk("tmo_fifo", 64'(out_valid), 64'd0);
        repeat (5) tick();
        chk("tmo_ntxn", 64'(log_q.size() - b), 64'd1);
        chk("tmo_idle", 64'(wbm_cyc), 64'd0);
        noack_adr = -1;

        sys_rst_n = 1'b0;
        repeat (3) tick();
        chk("rst2_buserr", 64'(bus_err), 64'd0);
        sys_rst_n = 1'b1;
        wait_init("r2");

        // bus error on the mouse payload read
        err_adr = 5;
        regs[2] = 32'd2;
        b = log_q.size();
        pend_set = clr_cnt + 1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (log_q.size() > b + 1 && !wbm_cyc) begin
                ok = 1'b1;
                break;
            end
        end
        pend_set = clr_cnt;
        chk("err_done", 64'(ok), 64'd1);
        chk("err_buserr", 64'(bus_err), 64'd1);
        chk("err_fifo", 64'(out_valid), 64'd0);
        repeat (4) tick();
        chk_seq("err", b, 2, 4'd2, 4'd5, 4'd0, 4'd0);
        err_adr = -1;

        // next report serviced normally; enable drops mid-sequence without aborting it
        regs[2] = 32'd1; regs[3] = 32'hFFFF_FFAB; regs[4] = 32'h1234_5678;
        b = log_q.size();
        pend_set = clr_cnt + 1;
        tick();
        enable = 1'b0;
        wait_quiet("kbd2");
        chk_seq("kbd2", b, 4, 4'd2, 4'd3, 4'd4, 4'd1);
        chk("kbd2_data", out_data, 64'h0000_00AB_1234_5678);
        chk("kbd2_typ", 64'(out_typ), 64'd1);
        pop_one();
        b = log_q.size();
        pend_set = clr_cnt + 1;
        repeat (10) tick();
        n = log_q.size() - b;
        chk("dis_ntxn", 64'(n), 64'd0);
        chk("dis_cyc", 64'(wbm_cyc), 64'd0);
        enable = 1'b1;
        wait_quiet("en");
        chk("en_ntxn", 64'(log_q.size() - b), 64'd4);
        chk("en_valid", 64'(out_valid), 64'd1);
        pop_one();

        sys_rst_n = 1'b0;
        repeat (3) tick();
        chk("rst3_buserr", 64'(bus_err), 64'd0);
        chk("rst3_valid", 64'(out_valid), 64'd0);
        sys_rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
